// File: rtl/seq_shifter.sv
// Multi-cycle barrel-free shifter: shifts up to STEP positions per clock under
// a valid/ready handshake and reports carry, zero and negative flags.
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_c,
    output logic             out_z,
    output logic             out_n
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [2:0] OP_LSL = 3'b001;
    localparam logic [2:0] OP_LSR = 3'b010;
    localparam logic [2:0] OP_ASR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    localparam logic [AMT_W-1:0] STEP_C = AMT_W'(STEP);

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   work_r;
    logic [2:0]         op_r;
    logic [AMT_W-1:0]   cnt_r;
    logic               carry_r;
    logic [WIDTH-1:0]   out_data_r;
    logic               out_c_r;
    logic               out_z_r;
    logic               out_n_r;
    logic               out_valid_r;
    logic               in_ready_r;

    logic [WIDTH-1:0]   shift_s;
    logic               carry_s;
    logic [AMT_W-1:0]   k_s;
    logic [AMT_W-1:0]   cnt_next_s;
    logic               zero_len_s;
    logic [WIDTH-1:0]   res_s;
    logic               res_c_s;
    logic               load_s;

    // One bit-position of the selected operation; returns {carry, value}.
    function automatic logic [WIDTH:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic [2:0]       op,
                                                 input logic             c);
        logic [WIDTH:0] r;
        case (op)
            OP_LSL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            OP_LSR:  r = {v[0], 1'b0, v[WIDTH-1:1]};
            OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
            default: r = {c, v};
        endcase
        return r;
    endfunction

    // Working-register update for one SHIFT cycle: k = min(cnt, STEP) positions.
    always_comb begin
        shift_s    = work_r;
        carry_s    = carry_r;
        k_s        = (cnt_r < STEP_C) ? cnt_r : STEP_C;
        cnt_next_s = cnt_r - k_s;
        for (int i = 0; i < STEP; i++) begin
            if (AMT_W'(i) < cnt_r) begin
                {carry_s, shift_s} = shift_one(shift_s, op_r, carry_s);
            end else begin
                shift_s = shift_s;
                carry_s = carry_s;
            end
        end
    end

    // Zero-length requests (amt 0, PASS or undefined op) bypass SHIFT.
    always_comb begin
        zero_len_s = (in_amt == {AMT_W{1'b0}}) || (in_op == 3'b000) || (in_op > OP_ROR);
    end

    // Next-state logic and the result that gets captured on entry to DONE.
    always_comb begin
        state_s = state_r;
        res_s   = shift_s;
        res_c_s = carry_s;
        case (state_r)
            ST_IDLE: begin
                res_s   = in_data;
                res_c_s = 1'b0;
                if (in_valid) begin
                    state_s = zero_len_s ? ST_DONE : ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_next_s == {AMT_W{1'b0}}) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        load_s = (state_r != ST_DONE) && (state_s == ST_DONE);
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            work_r      <= {WIDTH{1'b0}};
            op_r        <= 3'b000;
            cnt_r       <= {AMT_W{1'b0}};
            carry_r     <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_c_r     <= 1'b0;
            out_z_r     <= 1'b0;
            out_n_r     <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_r  <= in_data;
                        op_r    <= in_op;
                        cnt_r   <= in_amt;
                        carry_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    work_r  <= shift_s;
                    cnt_r   <= cnt_next_s;
                    carry_r <= carry_s;
                end
                default: begin
                    work_r <= work_r;
                end
            endcase
            // Flags are taken from the exact value being registered as the result.
            if (load_s) begin
                out_data_r <= res_s;
                out_c_r    <= res_c_s;
                out_z_r    <= (res_s == {WIDTH{1'b0}});
                out_n_r    <= res_s[WIDTH-1];
            end
            out_valid_r <= (state_s == ST_DONE);
            in_ready_r  <= (state_s == ST_IDLE);
        end
    end

    // in_ready is held low for as long as reset_n is asserted.
    assign in_ready  = in_ready_r & reset_n;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_c     = out_c_r;
    assign out_z     = out_z_r;
    assign out_n     = out_n_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: a STEP=1 and a STEP=4 instance share stimulus,
// selected by sel4; results are checked against hand-computed vectors.
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel4 = 1'b0;
    logic        in_valid_tb = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic [2:0]  in_op = 3'b000;
    logic [3:0]  in_amt = 4'd0;
    logic        out_ready = 1'b0;

    logic        iv1, ir1, ov1, oc1, oz1, on1;
    logic        iv4, ir4, ov4, oc4, oz4, on4;
    logic [15:0] od1, od4;

    logic        o_ready, o_valid, o_c, o_z, o_n;
    logic [15:0] o_data;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign iv1 = in_valid_tb & ~sel4;
    assign iv4 = in_valid_tb & sel4;
    assign o_ready = sel4 ? ir4 : ir1;
    assign o_valid = sel4 ? ov4 : ov1;
    assign o_data  = sel4 ? od4 : od1;
    assign o_c     = sel4 ? oc4 : oc1;
    assign o_z     = sel4 ? oz4 : oz1;
    assign o_n     = sel4 ? on4 : on1;

    seq_shifter #(.WIDTH(16), .AMT_W(4), .STEP(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1),
        .in_data(in_data), .in_op(in_op), .in_amt(in_amt),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_c(oc1), .out_z(oz1), .out_n(on1)
    );

    seq_shifter #(.WIDTH(16), .AMT_W(4), .STEP(4)) u_s4 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv4), .in_ready(ir4),
        .in_data(in_data), .in_op(in_op), .in_amt(in_amt),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
        .out_c(oc4), .out_z(oz4), .out_n(on4)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input bit s, input logic [2:0] op,
                         input logic [3:0] amt, input logic [15:0] d,
                         input logic [15:0] ed, input logic ec, input int el);
        int lat;
        sel4 = s;
        in_op = op;
        in_amt = amt;
        in_data = d;
        in_valid_tb = 1'b1;
        #1;
        chk({name, "_ready"}, 16'(o_ready), 16'd1);
        tick();
        in_valid_tb = 1'b0;
        lat = 1;
        while (!o_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 16'(lat), 16'(el));
        chk({name, "_data"}, o_data, ed);
        chk({name, "_c"}, 16'(o_c), 16'(ec));
        chk({name, "_z"}, 16'(o_z), 16'(ed == 16'h0000));
        chk({name, "_n"}, 16'(o_n), 16'(ed[15]));
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_drain_valid"}, 16'(o_valid), 16'd0);
        chk({name, "_drain_ready"}, 16'(o_ready), 16'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        tick();
        tick();
        sel4 = 1'b0;
        #1;
        chk("rst_ready_low", 16'(o_ready), 16'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_s1_ready", 16'(o_ready), 16'd1);
        chk("rst_s1_valid", 16'(o_valid), 16'd0);
        chk("rst_s1_data", o_data, 16'h0000);
        chk("rst_s1_flags", {13'd0, o_c, o_z, o_n}, 16'd0);
        sel4 = 1'b1;
        #1;
        chk("rst_s4_ready", 16'(o_ready), 16'd1);
        chk("rst_s4_valid", 16'(o_valid), 16'd0);

        // STEP=1, amt=1 on F0CF for each basic op.
        issue("pass", 1'b0, 3'b000, 4'd1, 16'hF0CF, 16'hF0CF, 1'b0, 1);
        drain("pass");
        issue("lsl1", 1'b0, 3'b001, 4'd1, 16'hF0CF, 16'hE19E, 1'b1, 2);
        drain("lsl1");
        issue("lsr1", 1'b0, 3'b010, 4'd1, 16'hF0CF, 16'h7867, 1'b1, 2);
        drain("lsr1");
        issue("asr1", 1'b0, 3'b011, 4'd1, 16'hF0CF, 16'hF867, 1'b1, 2);
        drain("asr1");
        issue("asr15", 1'b0, 3'b011, 4'd15, 16'hF0CF, 16'hFFFF, 1'b1, 16);
        drain("asr15");
        issue("lsl15", 1'b0, 3'b001, 4'd15, 16'h0003, 16'h8000, 1'b1, 16);
        drain("lsl15");
        issue("lsr_zero", 1'b0, 3'b010, 4'd1, 16'h0001, 16'h0000, 1'b1, 2);
        drain("lsr_zero");
        issue("op111", 1'b0, 3'b111, 4'd5, 16'h1234, 16'h1234, 1'b0, 1);
        drain("op111");

        // STEP=4 instance.
        issue("ror4", 1'b1, 3'b101, 4'd4, 16'hF0CF, 16'hFF0C, 1'b1, 2);
        drain("ror4");
        issue("rol6", 1'b1, 3'b100, 4'd6, 16'hF0CF, 16'h33FC, 1'b0, 3);
        drain("rol6");

        // Backpressure in DONE with an in_valid pulse that must be ignored.
        issue("bp", 1'b0, 3'b001, 4'd1, 16'h00F0, 16'h01E0, 1'b0, 2);
        in_data = 16'hFFFF;
        in_op = 3'b000;
        for (int i = 0; i < 5; i++) begin
            in_valid_tb = (i == 2);
            tick();
            chk("bp_valid", 16'(o_valid), 16'd1);
            chk("bp_data", o_data, 16'h01E0);
            chk("bp_ready", 16'(o_ready), 16'd0);
        end
        in_valid_tb = 1'b0;
        drain("bp");
        tick();
        tick();
        chk("bp_no_queue", 16'(o_valid), 16'd0);

        // Reset mid-SHIFT abandons the operation.
        sel4 = 1'b0;
        in_op = 3'b011;
        in_amt = 4'd10;
        in_data = 16'hF0CF;
        in_valid_tb = 1'b1;
        #1;
        tick();
        in_valid_tb = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_valid", 16'(o_valid), 16'd0);
        chk("mid_ready", 16'(o_ready), 16'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 16'(o_ready), 16'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_valid", 16'(o_valid), 16'd0);
        chk("post_rst_data", o_data, 16'h0000);
        chk("post_rst_flags", {13'd0, o_c, o_z, o_n}, 16'd0);
        chk("post_rst_ready", 16'(o_ready), 16'd1);
        issue("after_rst", 1'b0, 3'b001, 4'd1, 16'h0001, 16'h0002, 1'b0, 2);
        drain("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
